// File: rtl/prog_mem_loader_if.sv
// Byte-stream and program-memory write bundle for prog_mem_loader.
// The "slave" modport is the loader; "master" is whoever streams the image
// and observes the memory write port and core-release status.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 20
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [INS_W-1:0]  pm_din;
    logic              load_done;
    logic              cpu_reset;
    logic              load_err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, pm_we, pm_addr, pm_din, load_done, cpu_reset, load_err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, pm_we, pm_addr, pm_din, load_done, cpu_reset, load_err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory loader: takes a header byte (last word address L) followed
// by 3 bytes per 20-bit instruction, writes L+1 words starting at address 0,
// and keeps the core in reset (cpu_reset low) until the image is in place.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and an ERR state that keeps the core held on a bad image.
module prog_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_mem_loader_if.slave     bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {IDLE, HDR, B0, B1, B2, WR, DONE, CHK, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, B0, B1, B2, WR, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [INS_W-1:0]  din_q, din_d;
    logic              err_q, err_d;
    logic              ready;
    logic              take;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Ready is a pure state decode so the source sees it stable all cycle.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            HDR, B0, B1, B2: ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:             ready = 1'b1;
`endif
            default:         ready = 1'b0;
        endcase
    end

    assign take = bus.byte_valid && ready;

    // Next-state and datapath updates; a new start only restarts from a resting state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        din_d   = din_q;
        err_d   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
`ifdef PROG_LOADER_CHECKSUM_EN
            IDLE, DONE, ERR: begin
`else
            IDLE, DONE: begin
`endif
                if (bus.start) begin
                    addr_d  = '0;
                    err_d   = 1'b0;
                    state_d = HDR;
                end
            end
            HDR: if (take) begin
                last_d  = ADDR_W'(bus.byte_in);
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d  = bus.byte_in;
`endif
                state_d = B0;
            end
            B0: if (take) begin
                din_d[7:0] = bus.byte_in;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d     = csum_q ^ bus.byte_in;
`endif
                state_d    = B1;
            end
            B1: if (take) begin
                din_d[15:8] = bus.byte_in;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d      = csum_q ^ bus.byte_in;
`endif
                state_d     = B2;
            end
            B2: if (take) begin
                // Upper nibble is unused by the ISA; nonzero flags a malformed image
                // but the word is still written so the address sequence stays intact.
                din_d[19:16] = bus.byte_in[3:0];
                if (bus.byte_in[7:4] != 4'h0) err_d = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d       = csum_q ^ bus.byte_in;
`endif
                state_d      = WR;
            end
            WR: begin
                if (addr_q == last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = B0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: if (take) begin
                if (bus.byte_in == csum_q && !err_q) begin
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            din_q   <= din_d;
            err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = ready;
    assign bus.pm_we      = (state_q == WR);
    assign bus.pm_addr    = addr_q;
    assign bus.pm_din     = din_q;
    assign bus.load_done  = (state_q == DONE);
    assign bus.cpu_reset  = (state_q == DONE);
    assign bus.load_err   = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a word-level model of the image
// (expected write queue, error flag, XOR checksum) checked against every
// memory write, plus literal expectations for the documented example images.
module tb_prog_mem_loader;
    localparam int ADDR_W = 8;
    localparam int INS_W  = 20;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [INS_W-1:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(ADDR_W), .INS_W(INS_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W), .INS_W(INS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    wr_t         exp_q[$];
    wr_t         cmp_e;
    logic [7:0]  img[$];
    logic [INS_W-1:0] mem[256];
    bit          track = 0;
    bit          in_load = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare process: every write against the model, handshake/core-hold rules while loading.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pm_we) begin
                mem[bus.pm_addr] = bus.pm_din;
                n_wr++;
                if (track) begin
                    if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                    else begin
                        cmp_e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.pm_addr), 32'(cmp_e.a));
                        chk("wr_data", 32'(bus.pm_din), 32'(cmp_e.d));
                    end
                end
            end
            if (in_load) begin
                chk("ready_only_off_in_wr", 32'(bus.byte_ready), 32'(!bus.pm_we));
                chk("core_held", {30'd0, bus.load_done, bus.cpu_reset}, 0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Full load of img with header hdr; model derives writes, error and checksum.
    task automatic run_load(input string nm, input logic [7:0] hdr, input int gap, input int start_at);
        bit         err = 0;
        bit         exp_done;
        logic [7:0] cs = hdr;
        exp_q.delete();
        for (int i = 0; i <= int'(hdr); i++) begin
            wr_t w;
            w.a = i[ADDR_W-1:0];
            w.d = {img[3*i+2][3:0], img[3*i+1], img[3*i]};
            if (img[3*i+2][7:4] != 4'h0) err = 1;
            exp_q.push_back(w);
        end
        for (int i = 0; i < img.size(); i++) cs ^= img[i];
        track = 1;
        pulse_start();
        in_load = 1;
        send(hdr, gap);
        for (int i = 0; i < img.size(); i++) begin
            if (i == start_at) pulse_start();
            send(img[i], gap);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(cs, gap);
        exp_done = !err;
`else
        exp_done = 1;
`endif
        in_load = 0;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, "_writes_left"}, exp_q.size(), 0);
        chk({nm, "_load_done"}, 32'(bus.load_done), 32'(exp_done));
        chk({nm, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(exp_done));
        chk({nm, "_load_err"}, 32'(bus.load_err), 32'(err));
        track = 0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready"}, 32'(bus.byte_ready), 0);
        chk({nm, "_we"}, 32'(bus.pm_we), 0);
        chk({nm, "_addr"}, 32'(bus.pm_addr), 0);
        chk({nm, "_din"}, 32'(bus.pm_din), 0);
        chk({nm, "_done"}, 32'(bus.load_done), 0);
        chk({nm, "_cpu_reset"}, 32'(bus.cpu_reset), 0);
        chk({nm, "_err"}, 32'(bus.load_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_core_held", 32'(bus.cpu_reset), 0);

        // Documented two-word image, back to back.
        img = '{8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A};
        run_load("basic", 8'h01, 0, -1);
        chk("basic_mem0", 32'(mem[0]), 32'h51234);
        chk("basic_mem1", 32'(mem[1]), 32'hA5678);

        // Same image with 3 idle cycles before every byte.
        clear_mem();
        run_load("gapped", 8'h01, 3, -1);
        chk("gapped_mem0", 32'(mem[0]), 32'h51234);
        chk("gapped_mem1", 32'(mem[1]), 32'hA5678);

        // Bad upper nibble in B2.
        clear_mem();
        img = '{8'h11, 8'h22, 8'hF3};
        run_load("nibble", 8'h00, 0, -1);
        chk("nibble_mem0", 32'(mem[0]), 32'h32211);
        chk("nibble_err_lit", 32'(bus.load_err), 1);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("nibble_core_held", 32'(bus.cpu_reset), 0);
`else
        chk("nibble_done_lit", 32'(bus.load_done), 1);
`endif

        // Full 256-word image, no address wrap.
        clear_mem();
        img.delete();
        for (int i = 0; i < 256; i++) begin
            img.push_back(i[7:0]);
            img.push_back(8'h5A ^ i[7:0]);
            img.push_back({4'h0, i[3:0]});
        end
        wr0 = n_wr;
        run_load("full", 8'hFF, 0, -1);
        chk("full_write_count", n_wr - wr0, 256);
        chk("full_mem0", 32'(mem[0]), 32'h05A00);
        chk("full_mem255", 32'(mem[255]), 32'hFA5FF);

        // start while in B1 must be ignored.
        clear_mem();
        img = '{8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A};
        run_load("start_in_b1", 8'h01, 0, 1);
        chk("start_in_b1_mem0", 32'(mem[0]), 32'h51234);

        // Asynchronous reset in the middle of a load, then a full reload.
        pulse_start();
        send(8'h02, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_core_held", 32'(bus.cpu_reset), 0);
        clear_mem();
        img = '{8'hEF, 8'hCD, 8'h0B, 8'h10, 8'h32, 8'h04};
        run_load("reload", 8'h01, 0, -1);
        chk("reload_mem0", 32'(mem[0]), 32'hBCDEF);
        chk("reload_mem1", 32'(mem[1]), 32'h43210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
